// File: rtl/source_pkg.sv
// Shared types and constants for the multi-channel traffic source.
package source_pkg;

   typedef enum logic [1:0] {
      INCR  = 2'b00,
      LFSR  = 2'b01,
      CONST = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      DELAY   = 2'b00,
      PENDING = 2'b01,
      DONE    = 2'b10
   } ch_state_e;

   localparam logic [7:0] LFSR_TAPS_DEFAULT = 8'hB8;

endpackage

// File: rtl/valid_ready.sv
// Valid/ready handshake bundle: a beat moves when valid and ready are both high on a clock edge.
interface valid_ready #(
   parameter int DATA_WIDTH = 8
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport Master (output valid, output data, input ready);
   modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/source_channel.sv
// One traffic channel: inter-beat delay counter, payload generator and beat limiter.
module source_channel
   import source_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DELAY_BITS = 3,
   parameter int                    BEAT_BITS  = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(LFSR_TAPS_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  restart,
   input  logic [1:0]            mode,
   input  logic [DELAY_BITS-1:0] delay,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [BEAT_BITS-1:0]  beat_limit,
   input  logic                  grant,
   output logic                  request,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  done
);

   ch_state_e             state;
   logic [DELAY_BITS-1:0] count;
   logic [BEAT_BITS-1:0]  beats;
   logic [BEAT_BITS-1:0]  beats_next;
   logic [DATA_WIDTH-1:0] payload;
   logic [DATA_WIDTH-1:0] base_payload;
   logic [DATA_WIDTH-1:0] next_payload;
   logic                  need_load;
   logic                  delay_expired;

   // Starting payload for a mode: INCR counts up from 0, LFSR may never hold 0, CONST is the seed.
   function automatic logic [DATA_WIDTH-1:0] init_value(input logic [1:0]            m,
                                                        input logic [DATA_WIDTH-1:0] s);
      case (m)
         LFSR:    return (s == '0) ? DATA_WIDTH'(1) : s;
         CONST:   return s;
         default: return '0;
      endcase
   endfunction

   // Next payload in the sequence; the reserved mode code behaves as INCR.
   function automatic logic [DATA_WIDTH-1:0] advance(input logic [1:0]            m,
                                                     input logic [DATA_WIDTH-1:0] v,
                                                     input logic [DATA_WIDTH-1:0] s);
      case (m)
         LFSR:    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
         CONST:   return s;
         default: return v + DATA_WIDTH'(1);
      endcase
   endfunction

   // Seeds cannot be loaded by the asynchronous reset, so the first advance after reset starts from the seed-derived value.
   always_comb begin
      base_payload  = need_load ? init_value(mode, seed) : payload;
      next_payload  = advance(mode, base_payload, seed);
      beats_next    = beats + BEAT_BITS'(1);
      delay_expired = (delay == '0) || (count >= delay - DELAY_BITS'(1));
   end

   assign request = (state == PENDING);
   assign data    = payload;

   // Channel FSM: wait out the delay, offer one beat, count it and stop once the limit is reached.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= DELAY;
         count     <= '0;
         beats     <= '0;
         payload   <= '0;
         need_load <= 1'b1;
         done      <= 1'b0;
      end else if (restart) begin
         state     <= DELAY;
         count     <= '0;
         beats     <= '0;
         payload   <= init_value(mode, seed);
         need_load <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            DELAY: begin
               if (enable) begin
                  if (delay_expired) begin
                     payload   <= next_payload;
                     need_load <= 1'b0;
                     count     <= '0;
                     state     <= PENDING;
                  end else begin
                     count <= count + DELAY_BITS'(1);
                  end
               end
            end
            PENDING: begin
               if (grant) begin
                  beats <= beats_next;
                  count <= '0;
                  if ((beat_limit != '0) && (beats_next == beat_limit)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if ((delay == '0) && enable) begin
                     payload <= next_payload;
                  end else begin
                     state <= DELAY;
                  end
               end
            end
            DONE: begin
               done <= 1'b1;
            end
            default: begin
               state <= DELAY;
            end
         endcase
      end
   end

endmodule

// File: rtl/source_multi.sv
// Multi-channel traffic source: NUM_CH channels round-robin arbitrated onto one valid/ready bus.
module source_multi
   import source_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    DELAY_BITS = 3,
   parameter int                    NUM_CH     = 4,
   parameter int                    CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int                    BEAT_BITS  = 8,
   parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(LFSR_TAPS_DEFAULT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [2*NUM_CH-1:0]          mode,
   input  logic [DELAY_BITS*NUM_CH-1:0] delay,
   input  logic [DATA_WIDTH*NUM_CH-1:0] seed,
   input  logic [BEAT_BITS*NUM_CH-1:0]  beat_limit,
   input  logic                         restart,
   valid_ready.Master                   vrBus,
   output logic [CH_BITS-1:0]           ch_id,
   output logic [NUM_CH-1:0]            done
);

   logic [NUM_CH-1:0]     req;
   logic [NUM_CH-1:0]     grant;
   logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
   logic                  load_en;
   logic                  found;
   logic [CH_BITS-1:0]    grant_idx;
   logic [CH_BITS-1:0]    last_grant;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CH_BITS-1:0]    out_ch;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      source_channel #(
         .DATA_WIDTH (DATA_WIDTH),
         .DELAY_BITS (DELAY_BITS),
         .BEAT_BITS  (BEAT_BITS),
         .LFSR_TAPS  (LFSR_TAPS)
      ) u_channel (
         .clk        (clk),
         .reset      (reset),
         .enable     (enable),
         .restart    (restart),
         .mode       (mode[2*g +: 2]),
         .delay      (delay[DELAY_BITS*g +: DELAY_BITS]),
         .seed       (seed[DATA_WIDTH*g +: DATA_WIDTH]),
         .beat_limit (beat_limit[BEAT_BITS*g +: BEAT_BITS]),
         .grant      (grant[g]),
         .request    (req[g]),
         .data       (ch_data[g]),
         .done       (done[g])
      );
   end

   // The slice can take a new beat when it is empty or its current beat is leaving this cycle.
   assign load_en = !out_valid || vrBus.ready;

   // Round robin: lowest requester above last_grant wins, otherwise wrap to the lowest requester overall.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      sel_data  = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i] && (CH_BITS'(i) <= last_grant)) begin
            found     = 1'b1;
            grant_idx = CH_BITS'(i);
            sel_data  = ch_data[i];
         end
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i] && (CH_BITS'(i) > last_grant)) begin
            found     = 1'b1;
            grant_idx = CH_BITS'(i);
            sel_data  = ch_data[i];
         end
      end
   end

   // A grant is only issued when the slice actually loads, so a granted beat is never lost.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         grant[i] = load_en && found && (grant_idx == CH_BITS'(i));
      end
   end

   // Output register slice: holds data and ch_id stable while the sink stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         last_grant <= CH_BITS'(NUM_CH - 1);
      end else if (load_en) begin
         out_valid <= found;
         if (found) begin
            out_data   <= sel_data;
            out_ch     <= grant_idx;
            last_grant <= grant_idx;
         end
      end
   end

   assign vrBus.valid = out_valid;
   assign vrBus.data  = out_data;
   assign ch_id       = out_ch;

endmodule

// File: tb/tb_source_multi.sv
// Randomised scoreboard bench for source_multi with a directed single-channel companion instance.
module tb_source_multi;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        restart;
   logic [7:0]  mode;
   logic [11:0] delay;
   logic [31:0] seed;
   logic [31:0] beat_limit;
   logic [1:0]  ch_id;
   logic [3:0]  done;

   logic [1:0]  mode1;
   logic [2:0]  delay1;
   logic [7:0]  seed1;
   logic [7:0]  limit1;
   logic        restart1;
   logic [0:0]  ch_id1;
   logic [0:0]  done1;

   valid_ready #(.DATA_WIDTH(8)) vr ();
   valid_ready #(.DATA_WIDTH(8)) vr1 ();

   source_multi #(
      .DATA_WIDTH (8), .DELAY_BITS (3), .NUM_CH (4), .BEAT_BITS (8)
   ) dut (
      .clk (clk), .reset (reset), .enable (enable), .mode (mode), .delay (delay),
      .seed (seed), .beat_limit (beat_limit), .restart (restart), .vrBus (vr),
      .ch_id (ch_id), .done (done)
   );

   source_multi #(
      .DATA_WIDTH (8), .DELAY_BITS (3), .NUM_CH (1), .BEAT_BITS (8)
   ) dut1 (
      .clk (clk), .reset (reset), .enable (enable), .mode (mode1), .delay (delay1),
      .seed (seed1), .beat_limit (limit1), .restart (restart1), .vrBus (vr1),
      .ch_id (ch_id1), .done (done1)
   );

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         last_id = 3;
   int         last_cyc [4];
   bit         seen [4];
   bit         mon_en = 0;
   bit         rr_check = 0;
   bit         gap_check = 0;
   logic [7:0] exp_q [4][$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for beat spacing measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference payload sequence, from the mode rules.
   function automatic logic [7:0] model_init(input logic [1:0] m, input logic [7:0] s);
      if (m == 2'b01) return (s == 8'h00) ? 8'h01 : s;
      if (m == 2'b10) return s;
      return 8'h00;
   endfunction

   function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] v,
                                             input logic [7:0] s);
      if (m == 2'b01) return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
      if (m == 2'b10) return s;
      return 8'((int'(v) + 1) % 256);
   endfunction

   task automatic load_model(input int ch);
      logic [1:0] m;
      logic [7:0] s;
      logic [7:0] v;
      logic [7:0] lim;
      int         n;
      m   = mode[2*ch +: 2];
      s   = seed[8*ch +: 8];
      lim = beat_limit[8*ch +: 8];
      n   = (lim == 8'd0) ? 1024 : int'(lim);
      exp_q[ch].delete();
      v = model_init(m, s);
      for (int k = 0; k < n; k++) begin
         v = model_next(m, v, s);
         exp_q[ch].push_back(v);
      end
      seen[ch] = 1'b0;
   endtask

   task automatic load_all();
      for (int c = 0; c < 4; c++) load_model(c);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor: every accepted beat is matched against its channel's expected sequence.
   always @(negedge clk) begin
      int         ch;
      logic [7:0] e;
      if (mon_en && reset && vr.valid && vr.ready) begin
         ch = int'(ch_id);
         vectors++;
         if (exp_q[ch].size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat ch%0d: got data %0h, expected no beat", ch, vr.data);
         end else begin
            e = exp_q[ch].pop_front();
            if (vr.data !== e) begin
               miscompares++;
               $display("[TB] FAIL data ch%0d: got %0h, expected %0h", ch, vr.data, e);
            end
         end
         if (rr_check) begin
            vectors++;
            if (ch != (last_id + 1) % 4) begin
               miscompares++;
               $display("[TB] FAIL rr_order: got ch%0d, expected ch%0d", ch, (last_id + 1) % 4);
            end
         end
         if (gap_check && seen[ch]) begin
            vectors++;
            if (cyc - last_cyc[ch] != 4) begin
               miscompares++;
               $display("[TB] FAIL gap ch%0d: got %0d cycles, expected 4", ch, cyc - last_cyc[ch]);
            end
         end
         seen[ch]     = 1'b1;
         last_cyc[ch] = cyc;
         last_id      = ch;
      end
   end

   // Single-channel instance right after reset release: idle first cycle, then 1,2,3,... every cycle.
   task automatic check_single();
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            checkOutput("single_first_valid", 32'(vr1.valid), 32'd0);
         end else begin
            checkOutput("single_valid", 32'(vr1.valid), 32'd1);
            checkOutput("single_data", 32'(vr1.data), 32'(n - 1));
            checkOutput("single_ch_id", 32'(ch_id1), 32'd0);
         end
      end
   endtask

   task automatic drain();
      enable   = 1'b0;
      vr.ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus();
      load_all();
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      enable  = 1'b1;
   endtask

   task automatic wait_empty(input int ch, input int budget);
      int k;
      k = 0;
      while (exp_q[ch].size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      checkOutput("beats_delivered_timeout", 32'(exp_q[ch].size()), 32'd0);
   endtask

   initial begin
      logic [7:0] d0;
      logic [1:0] c0;
      reset      = 1'b0;
      enable     = 1'b1;
      restart    = 1'b0;
      restart1   = 1'b0;
      mode       = '0;
      delay      = '0;
      seed       = 32'h1234_5678;
      beat_limit = '0;
      mode1      = 2'b00;
      delay1     = 3'd0;
      seed1      = 8'h00;
      limit1     = 8'd0;
      vr.ready   = 1'b1;
      vr1.ready  = 1'b1;

      // Reset values.
      #2;
      checkOutput("reset_valid", 32'(vr.valid), 32'd0);
      checkOutput("reset_data", 32'(vr.data), 32'd0);
      checkOutput("reset_ch_id", 32'(ch_id), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);

      // All channels INCR back-to-back: round-robin ids and per-channel counts.
      load_all();
      last_id  = 3;
      mon_en   = 1'b1;
      rr_check = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      check_single();
      repeat (20) @(posedge clk);

      // Sink stall for 5 cycles mid-stream.
      #1;
      vr.ready = 1'b0;
      @(negedge clk);
      d0 = vr.data;
      c0 = ch_id;
      checkOutput("stall_valid_start", 32'(vr.valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("stall_valid", 32'(vr.valid), 32'd1);
         checkOutput("stall_data", 32'(vr.data), 32'(d0));
         checkOutput("stall_ch_id", 32'(ch_id), 32'(c0));
      end
      @(posedge clk);
      #1;
      vr.ready = 1'b1;
      repeat (20) @(posedge clk);
      rr_check = 1'b0;

      // Every channel with delay 3: beats of a channel land exactly 4 cycles apart.
      drain();
      for (int c = 0; c < 4; c++) begin
         mode[2*c +: 2] = 2'($urandom_range(0, 3));
         seed[8*c +: 8] = 8'($urandom);
      end
      delay      = {4{3'd3}};
      beat_limit = '0;
      gap_check  = 1'b1;
      applyStimulus();
      repeat (60) @(posedge clk);
      gap_check = 1'b0;

      // LFSR channel with a beat limit, then a restart replays the same sequence.
      drain();
      mode          = '0;
      mode[5:4]     = 2'b01;
      seed[23:16]   = 8'h01;
      delay         = '0;
      delay[8:6]    = 3'($urandom_range(0, 7));
      beat_limit    = '0;
      beat_limit[23:16] = 8'd4;
      applyStimulus();
      checkOutput("restart_clears_done", 32'(done), 32'd0);
      for (int r = 0; r < 2; r++) begin
         wait_empty(2, 200);
         repeat (5) @(posedge clk);
         #1;
         checkOutput("lfsr_done", 32'(done), 32'b0100);
         repeat (20) @(posedge clk);
         if (r == 0) begin
            drain();
            applyStimulus();
            checkOutput("restart_clears_done", 32'(done), 32'd0);
         end
      end

      // Random configurations with a jittery sink and pausing enable.
      for (int round = 0; round < 3; round++) begin
         drain();
         for (int c = 0; c < 4; c++) begin
            mode[2*c +: 2]       = 2'($urandom_range(0, 3));
            delay[3*c +: 3]      = 3'($urandom_range(0, 7));
            seed[8*c +: 8]       = 8'($urandom);
            beat_limit[8*c +: 8] = 8'($urandom_range(0, 6));
         end
         applyStimulus();
         for (int k = 0; k < 400; k++) begin
            vr.ready = ($urandom_range(0, 9) < 7);
            enable   = ($urandom_range(0, 9) != 0);
            @(posedge clk);
            #1;
         end
         vr.ready = 1'b1;
         enable   = 1'b1;
         repeat (300) @(posedge clk);
         #1;
         for (int c = 0; c < 4; c++) begin
            if (beat_limit[8*c +: 8] != 8'd0) begin
               checkOutput("rand_beats_delivered", 32'(exp_q[c].size()), 32'd0);
               checkOutput("rand_done_set", 32'(done[c]), 32'd1);
            end else begin
               checkOutput("rand_done_clear", 32'(done[c]), 32'd0);
            end
         end
      end

      // Reset while a beat is stalled on the bus; the sequence restarts from 1.
      drain();
      mode       = '0;
      delay      = '0;
      beat_limit = '0;
      applyStimulus();
      repeat (10) @(posedge clk);
      #1;
      vr.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre_reset_valid", 32'(vr.valid), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_valid", 32'(vr.valid), 32'd0);
      checkOutput("async_reset_data", 32'(vr.data), 32'd0);
      checkOutput("async_reset_ch_id", 32'(ch_id), 32'd0);
      checkOutput("async_reset_done", 32'(done), 32'd0);
      load_all();
      last_id  = 3;
      rr_check = 1'b1;
      @(posedge clk);
      #1;
      vr.ready = 1'b1;
      reset    = 1'b1;
      check_single();
      repeat (20) @(posedge clk);
      #1;
      rr_check = 1'b0;
      mon_en   = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/source_multi.md
Name: source_multi

Overview:
- Parametrised multi-channel successor to the single-channel delayed data source.
- NUM_CH independent channels. Each channel has its own programmable inter-beat delay, payload generator (incrementing, LFSR or constant) and optional beat limit.
- Channel beats are round-robin arbitrated onto one valid_ready master bus, with a channel-ID sideband.
- Used as a stimulus and traffic generator in front of sinks, FIFOs and arbiters under test.

Parameters:
- DATA_WIDTH, 8, payload width on vrBus.data.
- DELAY_BITS, 3, width of each per-channel delay field.
- NUM_CH, 4, number of channels, 1..16.
- CH_BITS, $clog2(NUM_CH) (minimum 1), width of the channel-ID output.
- BEAT_BITS, 8, width of the per-channel beat limit and beat counter.
- LFSR_TAPS, 8'hB8, Galois feedback polynomial used when mode = LFSR (for DATA_WIDTH = 8).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- enable  in  1  1 = channels may start new delays and beats; 0 = pause.
- mode  in  2*NUM_CH  per-channel payload mode: 00 INCR, 01 LFSR, 10 CONST, 11 reserved (treated as INCR).
- delay  in  DELAY_BITS*NUM_CH  per-channel idle cycles between beats; 0 = back-to-back.
- seed  in  DATA_WIDTH*NUM_CH  per-channel LFSR seed / constant value, sampled on reset release and on restart.
- beat_limit  in  BEAT_BITS*NUM_CH  beats per channel before it stops; 0 = unlimited.
- restart  in  1  single-cycle pulse; clears all beat counters and done flags, reloads seeds.
- vrBus  modport valid_ready.Master  data = payload, plus valid and ready.
- ch_id  out  CH_BITS  channel that owns the current vrBus beat.
- done  out  NUM_CH  per-channel 1 once beat_limit beats are accepted.

Behaviour:
- Reset (reset = 0): vrBus.valid=0, vrBus.data=0, ch_id=0, done=0.
  - All channels go to DELAY with count 0 and beat counter 0.
  - INCR payload registers go to 0; the first INCR beat is 1.
  - LFSR registers load seed, forced to 1 if seed = 0.
- Channel FSM (source_channel), states DELAY, PENDING, DONE:
  - DELAY: while enable=1, count increments. When delay==0 or count >= delay-1, advance the payload and go to PENDING. The >= comparison means a delay lowered mid-count exits on the next cycle with no wrap.
  - PENDING: hold payload; request the arbiter. On grant, with the beat accepted by the output stage, increment the beat counter and clear count.
    - If beat_limit != 0 and the new counter equals beat_limit, go to DONE.
    - Otherwise, if delay == 0 and enable == 1, advance the payload and stay in PENDING; if not, go to DELAY.
  - DONE: done bit = 1; no requests. Leave only on restart or reset.
  - enable=0: DELAY count freezes. A PENDING channel keeps its request; a beat already on the bus is never withdrawn.
- Payload advance:
  - INCR: +1 modulo 2^DATA_WIDTH; 0xFF -> 0x00 (wrap) for width 8.
  - LFSR: shift right; if the shifted-out bit is 1, XOR with LFSR_TAPS.
  - CONST: stays at seed.
- Output stage (one register slice):
  - Loads when vrBus.valid=0 or when (vrBus.valid && vrBus.ready).
  - While valid && !ready, data and ch_id stay stable and valid stays 1.
  - The arbiter grants the first PENDING channel at or after last_grant+1 (mod NUM_CH); last_grant resets to NUM_CH-1.
  - Grant and load happen in the same cycle.
  - Zero-delay steady state: with ready=1 held, the bus carries one beat every cycle.
- Latency: a channel entering PENDING in cycle t has its beat valid on the bus at t+1 at the earliest.
- restart: in its cycle, every channel goes to DELAY with count 0 and beat counter 0, seeds and INCR counters are reloaded, and done is cleared. An in-flight bus beat still completes normally.
- Simultaneous restart and acceptance of a beat that would complete a channel: restart wins; done stays 0.

Decomposition:
- Package source_pkg holds:
  - mode_e enum (INCR, LFSR, CONST);
  - ch_state_e enum (DELAY, PENDING, DONE);
  - the default LFSR_TAPS constant.
- Sub-module source_channel: one instance per channel via generate. It contains the FSM, delay counter, payload generator and beat counter.
- The top level holds the round-robin arbiter and the output register slice.

Test Plan:
- NUM_CH=1, mode INCR, delay=0, ready=1 held -> data 1,2,3,... one per cycle, ch_id=0, valid continuously 1 from the 2nd cycle after reset release.
- Ch0 delay=3, ready=1 -> consecutive accepted beats exactly 4 cycles apart; data 1,2,3.
- All 4 channels delay=0, INCR, ready=1 -> ch_id sequence 0,1,2,3,0,...; each channel's data increments by 1 per its own beat.
- ready held 0 for 5 cycles mid-stream -> data and ch_id unchanged and valid=1 throughout; no beat lost or duplicated after ready returns.
- Ch2 mode LFSR, seed=8'h01, beat_limit=4 -> data 0xB8, 0x5C, 0x2E, 0x17; done[2] rises after the 4th acceptance; no further ch_id=2 beats; restart pulse -> same sequence repeats.
- Reset (reset=0) asserted while valid=1 and ready=0 -> valid drops asynchronously; after release the INCR sequence restarts at 1.
